// File: rtl/simple_gmii_pkg.sv
// Shared register map, line constants and state encodings for simple_gmii.
package simple_gmii_pkg;

  localparam logic [2:0] REG_TX_DATA  = 3'd0;
  localparam logic [2:0] REG_TX_CTRL  = 3'd1;
  localparam logic [2:0] REG_TX_STAT  = 3'd2;
  localparam logic [2:0] REG_RX_DATA  = 3'd3;
  localparam logic [2:0] REG_RX_STAT  = 3'd4;
  localparam logic [2:0] REG_RX_COUNT = 3'd5;
  localparam logic [2:0] REG_RX_CTRL  = 3'd6;
  localparam logic [2:0] REG_ID       = 3'd7;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [2:0] PREAMBLE_LEN  = 3'd7;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_PREAMBLE = 2'd1,
    TX_SFD      = 2'd2,
    TX_DATA     = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_HUNT = 2'd1,
    RX_DATA = 2'd2
  } rx_state_t;

endpackage

// File: rtl/simple_gmii_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy count.
module gmii_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and count update; clear empties the FIFO in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/simple_gmii.sv
// Processor-mapped GMII MAC: TX FIFO + framer, RX FIFO + deframer.
module simple_gmii
  import simple_gmii_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [7:0]  ID_VALUE   = 8'h47
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       io_select,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [2:0] io_addr,
  input  logic [7:0] io_data_in,
  output logic [7:0] io_data_out,
  output logic [7:0] tx_data,
  output logic       tx_dv,
  output logic       tx_er,
  output logic       tx_clk,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  input  logic       rx_er,
  input  logic       rx_clk
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic             unused_rx_clk;
  logic [CW-1:0]    unused_tx_count;

  logic             wr_act, rd_act, wr_act_q, rd_act_q;
  logic [2:0]       rd_addr_q;
  logic             wr_fire, rd_done;
  logic             tx_push, tx_send, tx_flush, tx_pop;
  logic             rx_clr, rx_flush, rx_pop, rx_push, frame_set;
  logic [7:0]       tx_head, rx_head;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]    rx_count;

  tx_state_t        tx_state_q, tx_state_d;
  logic [2:0]       pre_cnt_q, pre_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_dv_q, tx_dv_d;

  rx_state_t        rx_state_q, rx_state_d;
  logic             rx_dv_q;
  logic             ovf_q, ovf_d, err_q, err_d, done_q, done_d;

  assign unused_rx_clk = rx_clk;
  assign tx_clk = clk;
  assign tx_er  = 1'b0;
  assign tx_data = tx_data_q;
  assign tx_dv   = tx_dv_q;

  // Strobe decode: writes act on assertion, reads pop on release.
  assign wr_act  = io_select & ~wr_n;
  assign rd_act  = io_select & ~rd_n;
  assign wr_fire = wr_act & ~wr_act_q;
  assign rd_done = rd_act_q & ~rd_act;

  assign tx_push  = wr_fire && (io_addr == REG_TX_DATA);
  assign tx_flush = wr_fire && (io_addr == REG_TX_CTRL) && io_data_in[1];
  assign tx_send  = wr_fire && (io_addr == REG_TX_CTRL) && io_data_in[0] && !io_data_in[1];
  assign rx_clr   = wr_fire && (io_addr == REG_RX_CTRL) && io_data_in[0];
  assign rx_flush = wr_fire && (io_addr == REG_RX_CTRL) && io_data_in[1];
  assign rx_pop   = rd_done && (rd_addr_q == REG_RX_DATA);

  // Strobe history and the address latched during a read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      if (rd_act) rd_addr_q <= io_addr;
    end
  end

  gmii_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i(clk), .rst_ni(reset_n), .clear_i(tx_flush),
    .push_i(tx_push), .pop_i(tx_pop), .data_i(io_data_in),
    .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty),
    .count_o(unused_tx_count)
  );

  gmii_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk_i(clk), .rst_ni(reset_n), .clear_i(rx_flush),
    .push_i(rx_push), .pop_i(rx_pop), .data_i(rx_data),
    .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty),
    .count_o(rx_count)
  );

  // TX next state: outputs are computed for the byte leaving on the next edge,
  // so the send edge already emits the first preamble byte.
  always_comb begin
    tx_state_d = tx_state_q;
    pre_cnt_d  = pre_cnt_q;
    tx_data_d  = '0;
    tx_dv_d    = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_send && !tx_empty) begin
          tx_state_d = TX_PREAMBLE;
          pre_cnt_d  = 3'd1;
          tx_data_d  = PREAMBLE_BYTE;
          tx_dv_d    = 1'b1;
        end
      end
      TX_PREAMBLE: begin
        tx_dv_d = 1'b1;
        if (pre_cnt_q == PREAMBLE_LEN) begin
          tx_state_d = TX_SFD;
          tx_data_d  = SFD_BYTE;
        end else begin
          pre_cnt_d = pre_cnt_q + 3'd1;
          tx_data_d = PREAMBLE_BYTE;
        end
      end
      TX_SFD, TX_DATA: begin
        if (!tx_empty) begin
          tx_state_d = TX_DATA;
          tx_data_d  = tx_head;
          tx_dv_d    = 1'b1;
          tx_pop     = 1'b1;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_flush) begin
      tx_state_d = TX_IDLE;
      tx_data_d  = '0;
      tx_dv_d    = 1'b0;
      tx_pop     = 1'b0;
    end
  end

  // TX state and registered GMII outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      pre_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_dv_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      pre_cnt_q  <= pre_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_dv_q    <= tx_dv_d;
    end
  end

  // RX next state: hunt for SFD, then store payload until rx_dv drops.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_dv && !rx_dv_q) rx_state_d = RX_HUNT;
      RX_HUNT: begin
        if (!rx_dv) begin
          rx_state_d = RX_IDLE;
          frame_set  = 1'b1;
        end else if (rx_data == SFD_BYTE) begin
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (!rx_dv) begin
          rx_state_d = RX_IDLE;
          frame_set  = 1'b1;
        end else begin
          rx_push = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Sticky RX flags; a new event in the clearing cycle wins.
  always_comb begin
    ovf_d  = (ovf_q & ~rx_clr) | (rx_push & rx_full);
    err_d  = (err_q & ~rx_clr) | (rx_dv & rx_er);
    done_d = (done_q & ~rx_clr) | frame_set;
  end

  // RX state, rx_dv history and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_dv_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_dv_q    <= rx_dv;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Register read mux; write-only registers read as zero.
  always_comb begin
    io_data_out = '0;
    case (io_addr)
      REG_TX_STAT:  io_data_out = {5'b0, (tx_state_q != TX_IDLE), tx_full, tx_empty};
      REG_RX_DATA:  io_data_out = rx_empty ? 8'h00 : rx_head;
      REG_RX_STAT:  io_data_out = {4'b0, ovf_q, err_q, done_q, ~rx_empty};
      REG_RX_COUNT: io_data_out = 8'(rx_count);
      REG_ID:       io_data_out = ID_VALUE;
      default:      io_data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_simple_gmii.sv
// Directed/randomized bench for simple_gmii with a queue-based reference model.
module tb_simple_gmii;

  localparam int unsigned DEPTH = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       io_select, rd_n, wr_n;
  logic [2:0] io_addr;
  logic [7:0] io_data_in, io_data_out;
  logic [7:0] tx_data, rx_data;
  logic       tx_dv, tx_er, tx_clk, rx_dv, rx_er, rx_clk;

  logic       loop_en;
  logic [7:0] rx_data_drv;
  logic       rx_dv_drv, rx_er_drv;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] cap_q[$];
  bit         m_ovf, m_err, m_done;

  assign rx_data = loop_en ? tx_data : rx_data_drv;
  assign rx_dv   = loop_en ? tx_dv   : rx_dv_drv;
  assign rx_er   = loop_en ? tx_er   : rx_er_drv;
  assign rx_clk  = clk;

  always #5 clk = ~clk;

  simple_gmii #(.FIFO_DEPTH(DEPTH), .ID_VALUE(8'h47)) dut (
    .clk(clk), .reset_n(reset_n), .io_select(io_select), .rd_n(rd_n), .wr_n(wr_n),
    .io_addr(io_addr), .io_data_in(io_data_in), .io_data_out(io_data_out),
    .tx_data(tx_data), .tx_dv(tx_dv), .tx_er(tx_er), .tx_clk(tx_clk),
    .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er), .rx_clk(rx_clk)
  );

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rx_status();
    return {4'b0, m_ovf, m_err, m_done, (rxq.size() != 0)};
  endfunction

  task automatic io_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_data_in = d; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
  endtask

  task automatic io_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    io_addr = a; rd_n = 1'b0;
    @(negedge clk);
    d = io_data_out;
    rd_n = 1'b1;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    io_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic tx_push(input logic [7:0] b);
    io_write(3'd0, b);
    if (txq.size() < DEPTH) txq.push_back(b);
  endtask

  task automatic rx_model_push(input logic [7:0] b);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else m_ovf = 1'b1;
  endtask

  // Send the queued TX payload and compare the whole frame on the wire.
  task automatic send_and_capture(input string tag);
    logic [7:0] exp_f[$];
    exp_f.delete();
    for (int unsigned i = 0; i < 7; i++) exp_f.push_back(8'h55);
    exp_f.push_back(8'hD5);
    foreach (txq[i]) exp_f.push_back(txq[i]);
    cap_q.delete();
    @(negedge clk);
    io_addr = 3'd1; io_data_in = 8'h01; wr_n = 1'b0;
    for (int unsigned c = 0; c < 300; c++) begin
      @(negedge clk);
      wr_n = 1'b1; io_addr = 3'd2;
      if (tx_dv) cap_q.push_back(tx_data);
      else if (cap_q.size() > 0) break;
      if (c == 3) check({tag, " busy"}, io_data_out, 8'h04);
    end
    check({tag, " dv_len"}, 8'(cap_q.size()), 8'(exp_f.size()));
    for (int unsigned i = 0; i < exp_f.size(); i++)
      check({tag, " byte"}, (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_f[i]);
    txq.delete();
  endtask

  // Drive an RX frame directly: preamble, SFD, random payload, optional rx_er.
  task automatic rx_frame(input int unsigned plen, input int unsigned nbytes, input int er_idx);
    logic [7:0] b;
    @(negedge clk);
    for (int unsigned i = 0; i < plen; i++) begin
      rx_dv_drv = 1'b1; rx_data_drv = 8'h55; rx_er_drv = 1'b0;
      @(negedge clk);
    end
    rx_dv_drv = 1'b1; rx_data_drv = 8'hD5;
    @(negedge clk);
    for (int i = 0; i < int'(nbytes); i++) begin
      b = 8'($urandom);
      rx_data_drv = b;
      rx_er_drv = (i == er_idx);
      if (i == er_idx) m_err = 1'b1;
      rx_model_push(b);
      @(negedge clk);
    end
    rx_dv_drv = 1'b0; rx_er_drv = 1'b0; rx_data_drv = 8'h00;
    m_done = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    int unsigned n;
    reset_n = 1'b0; io_select = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    io_addr = 3'd2; io_data_in = 8'h00; loop_en = 1'b0;
    rx_data_drv = 8'h00; rx_dv_drv = 1'b0; rx_er_drv = 1'b0;
    m_ovf = 0; m_err = 0; m_done = 0;
    repeat (3) @(negedge clk);
    check("reset tx_dv", {7'b0, tx_dv}, 8'h00);
    check("reset tx_data", tx_data, 8'h00);
    check("reset tx_stat", io_data_out, 8'h01);
    reset_n = 1'b1;

    check_reg("reg2 after reset", 3'd2, 8'h01);
    check_reg("reg4 after reset", 3'd4, 8'h00);
    check_reg("reg7 id", 3'd7, 8'h47);
    check_reg("reg5 after reset", 3'd5, 8'h00);
    check_reg("reg0 wo reads 0", 3'd0, 8'h00);
    check_reg("reg1 wo reads 0", 3'd1, 8'h00);
    check_reg("reg6 wo reads 0", 3'd6, 8'h00);

    // Directed frame in loopback.
    loop_en = 1'b1;
    tx_push(8'hA1); tx_push(8'hB2); tx_push(8'hC3);
    foreach (txq[i]) rx_model_push(txq[i]);
    send_and_capture("tx abc");
    m_done = 1'b1;
    repeat (3) @(negedge clk);
    check_reg("loop reg5", 3'd5, 8'(rxq.size()));
    check_reg("loop reg4", 3'd4, exp_rx_status());
    for (int unsigned i = 0; i < 3; i++) check_reg("loop reg3", 3'd3, rxq.pop_front());
    check_reg("loop reg4 drained", 3'd4, exp_rx_status());
    loop_en = 1'b0;
    io_write(3'd6, 8'h03);
    m_ovf = 0; m_err = 0; m_done = 0; rxq.delete();
    check_reg("rx cleared", 3'd4, exp_rx_status());

    // Held write strobe pushes once.
    @(negedge clk);
    io_addr = 3'd0; io_data_in = 8'h11; wr_n = 1'b0;
    repeat (5) @(negedge clk);
    wr_n = 1'b1;
    txq.push_back(8'h11);
    check_reg("held write stat", 3'd2, 8'h00);
    send_and_capture("tx held");

    // Send with empty FIFO is ignored.
    io_write(3'd1, 8'h01);
    repeat (3) @(negedge clk);
    check("empty send dv", {7'b0, tx_dv}, 8'h00);
    check_reg("empty send stat", 3'd2, 8'h01);

    // Random TX frames.
    for (int unsigned f = 0; f < 3; f++) begin
      n = $urandom_range(1, 10);
      for (int unsigned i = 0; i < n; i++) tx_push(8'($urandom));
      send_and_capture("tx rand");
    end

    // Flush aborts a frame in progress.
    for (int unsigned i = 0; i < 4; i++) tx_push(8'($urandom));
    io_write(3'd1, 8'h01);
    repeat (2) @(negedge clk);
    check("pre-abort dv", {7'b0, tx_dv}, 8'h01);
    io_write(3'd1, 8'h02);
    txq.delete();
    check("abort dv", {7'b0, tx_dv}, 8'h00);
    check_reg("abort stat", 3'd2, 8'h01);

    // Random RX frames.
    for (int unsigned f = 0; f < 3; f++) begin
      rx_frame($urandom_range(1, 7), $urandom_range(1, 8), -1);
      check_reg("rx rand count", 3'd5, 8'(rxq.size()));
      check_reg("rx rand stat", 3'd4, exp_rx_status());
      while (rxq.size() > 0) check_reg("rx rand data", 3'd3, rxq.pop_front());
      check_reg("rx rand drained", 3'd4, exp_rx_status());
      io_write(3'd6, 8'h01);
      m_ovf = 0; m_err = 0; m_done = 0;
    end
    check_reg("rx empty data", 3'd3, 8'h00);

    // Overflow: DEPTH+1 payload bytes.
    rx_frame(7, DEPTH + 1, -1);
    check_reg("ovf count", 3'd5, 8'(rxq.size()));
    check_reg("ovf stat", 3'd4, exp_rx_status());
    io_write(3'd6, 8'h01);
    m_ovf = 0; m_err = 0; m_done = 0;
    check_reg("ovf cleared", 3'd4, exp_rx_status());
    check_reg("ovf head", 3'd3, rxq.pop_front());
    check_reg("ovf count after pop", 3'd5, 8'(rxq.size()));
    io_write(3'd6, 8'h02);
    rxq.delete();
    check_reg("rx flush count", 3'd5, 8'h00);
    check_reg("rx flush stat", 3'd4, exp_rx_status());

    // rx_er mid-frame.
    rx_frame(3, 4, 2);
    check_reg("rx_er stat", 3'd4, exp_rx_status());
    io_write(3'd6, 8'h03);
    m_ovf = 0; m_err = 0; m_done = 0; rxq.delete();
    check_reg("rx_er cleared", 3'd4, exp_rx_status());

    // Asynchronous reset mid-frame.
    for (int unsigned i = 0; i < 3; i++) tx_push(8'($urandom));
    io_write(3'd1, 8'h01);
    repeat (3) @(negedge clk);
    check("pre-reset dv", {7'b0, tx_dv}, 8'h01);
    #2 reset_n = 1'b0;
    #1 check("async reset dv", {7'b0, tx_dv}, 8'h00);
    check("async reset data", tx_data, 8'h00);
    txq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    check_reg("post-reset reg2", 3'd2, 8'h01);
    check_reg("post-reset reg5", 3'd5, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_gmii.md
SIMPLE_GMII -- requirements
Module: simple_gmii

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, which sets the TX and RX FIFO depth (power of two, max 128).
REQ-002 SHALL have parameter ID_VALUE, default 8'h47, the constant returned at register 7.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 io_select  input  1  I/O decode select, driven from the processor's upper I/O address bits.
REQ-006 rd_n  input  1  active-low read strobe.
REQ-007 wr_n  input  1  active-low write strobe.
REQ-008 io_addr  input  3  register index.
REQ-009 io_data_in  input  8  write data.
REQ-010 io_data_out  output  8  read data, combinational from io_addr and state.
REQ-011 tx_data  output  8  GMII transmit byte, registered.
REQ-012 tx_dv  output  1  transmit valid, registered.
REQ-013 tx_er  output  1  transmit error, constant 0.
REQ-014 tx_clk  output  1  forwarded clock, equal to clk.
REQ-015 rx_data  input  8  GMII receive byte, sampled on clk.
REQ-016 rx_dv  input  1  receive valid.
REQ-017 rx_er  input  1  receive error.
REQ-018 rx_clk  input  1  must be the same clock as clk (loopback); it is not used as a clock inside the block.

Function
REQ-019 A write fires once, on the first clk where io_select & !wr_n is true (rising-edge detect of the strobe); a held strobe SHALL NOT repeat it.
REQ-020 A read pop fires once, on the clk where io_select & !rd_n falls from true to false; io_data_out SHALL stay stable while the strobe is held.
REQ-021 Register map:
- 0 W: push io_data_in into TX FIFO; ignored when full.
- 1 W: bit0 send, bit1 flush TX FIFO.
- 2 R: TX status = {5'b0, busy, full, empty}.
- 3 R: RX FIFO head byte (0 when empty); pop on read completion.
- 4 R: RX status = {4'b0, overflow, rx_error, frame_done, nonempty}.
- 5 R: RX FIFO byte count.
- 6 W: bit0 clears overflow, rx_error and frame_done; bit1 flushes RX FIFO.
- 7 R: ID_VALUE.
- Reads of W-only registers SHALL return 0.
REQ-022 TX state machine has states IDLE, PREAMBLE, SFD, DATA.
- IDLE: send with a non-empty FIFO moves to PREAMBLE; send with an empty FIFO is ignored.
- PREAMBLE: drives 7 bytes of 8'h55.
- SFD: drives 1 byte of 8'hD5.
- DATA: drives one FIFO byte per clk until the FIFO is empty, then returns to IDLE.
- tx_dv is 1 in PREAMBLE, SFD and DATA only.
REQ-023 busy = 1 whenever the TX state is not IDLE; send while busy SHALL be ignored; pushes while busy are allowed and are transmitted in the same frame if they arrive before the FIFO empties.
REQ-024 TX flush while busy SHALL abort the frame: return to IDLE the next clk with tx_dv deasserted.
REQ-025 RX state machine has states IDLE, HUNT, DATA.
- IDLE: rx_dv rising moves to HUNT.
- HUNT: bytes are discarded until 8'hD5 is seen, then the state moves to DATA.
- DATA: every rx_dv byte is pushed into the RX FIFO.
- rx_dv falling (from HUNT or DATA) sets frame_done and returns to IDLE.
REQ-026 rx_er while rx_dv is high SHALL set rx_error (sticky).
REQ-027 An RX push while the FIFO is full SHALL drop the byte and set overflow (sticky).
REQ-028 FIFOs use wrap-around pointers plus a count; a simultaneous push and pop SHALL keep the count unchanged.
REQ-029 The RX byte count SHALL report FIFO_DEPTH exactly when full.

Reset
REQ-030 While reset_n = 0:
- tx_data = 0, tx_dv = 0;
- both FIFOs empty, all pointers and counts 0;
- all flags 0;
- both state machines IDLE.
REQ-031 Reset asserted mid-frame SHALL drop tx_dv immediately (asynchronously).

Structure
REQ-032 Register indices, preamble/SFD constants and state encodings SHALL live in a shared package simple_gmii_pkg.
REQ-033 One sub-module gmii_fifo (synchronous FIFO with push, pop, full, empty, count) SHALL be instantiated twice.

Verification
REQ-034 After reset: read reg 2 -> 8'h01; reg 4 -> 8'h00; reg 7 -> 8'h47.
REQ-035 Push 8'hA1, 8'hB2, 8'hC3, then write reg 1 = 1 -> tx_dv high for exactly 11 clks carrying 55×7, D5, A1, B2, C3.
REQ-036 With rx tied to tx (loopback), send the frame of REQ-035 -> reg 5 = 3; reg 4 = 8'h03; three reads of reg 3 return A1, B2, C3; then reg 4 bit0 = 0.
REQ-037 Hold wr_n low 5 clks on reg 0 with data 8'h11 -> TX FIFO gains exactly one byte.
REQ-038 Inject FIFO_DEPTH+1 payload bytes -> count = 64 and overflow = 1; write reg 6 = 1 -> overflow = 0.
REQ-039 Assert rx_er for one clk mid-frame -> reg 4 bit2 = 1; assert reset_n low mid-TX -> tx_dv = 0 at once and reg 2 reads 8'h01 after release.
